// File: rtl/spi_pkg.sv
// Definitions shared by the SPI register controller and the SPI slave core:
// FSM state encoding, command-byte layout and the default fill byte.
package spi_pkg;

  localparam int DATA_LENGTH = 8;
  localparam int CMD_RD_BIT  = 7;

  localparam logic [DATA_LENGTH-1:0] FILL_BYTE_DEFAULT = 8'hA5;

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    WR,
    RD_WAIT,
    RD_STREAM
  } state_e;

  function automatic logic is_read_cmd(input logic [DATA_LENGTH-1:0] cmd);
    return cmd[CMD_RD_BIT];
  endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-stage synchroniser for one asynchronous level, followed by
// single-cycle rise/fall pulses on the synchronised value.
module spi_sync_edge #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic rise_o,
  output logic fall_o
);

  // Fewer than two stages gives no metastability protection.
  localparam int N = (STAGES < 2) ? 2 : STAGES;

  logic [N-1:0] sync_q;
  logic         prev_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[N-2:0], d_i};
      prev_q <= sync_q[N-1];
    end
  end

  assign rise_o = sync_q[N-1] & ~prev_q;
  assign fall_o = ~sync_q[N-1] & prev_q;

endmodule

// File: rtl/spi_reg_ctrl.sv
// Turns the SPI slave's byte stream into register-bus writes and reads:
// the first byte of a frame is a command, later bytes are data or read slots.
module spi_reg_ctrl
  import spi_pkg::*;
#(
  parameter int                      ADDR_W      = 7,
  parameter int                      SYNC_STAGES = 2,
  parameter int                      RD_TIMEOUT  = 15,
  parameter logic [DATA_LENGTH-1:0]  FILL_BYTE   = FILL_BYTE_DEFAULT
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   spi_ss,
  input  logic                   rx_toggle,
  input  logic [DATA_LENGTH-1:0] rx_byte,
  output logic [DATA_LENGTH-1:0] tx_byte,
  output logic [ADDR_W-1:0]      reg_addr,
  output logic [DATA_LENGTH-1:0] reg_wdata,
  output logic                   reg_we,
  output logic                   reg_re,
  input  logic [DATA_LENGTH-1:0] reg_rdata,
  input  logic                   reg_rvalid,
  output logic                   busy,
  output logic                   err_sticky
);

  localparam int              CNT_W   = $clog2(RD_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(RD_TIMEOUT - 1);

  logic ss_rise, ss_fall;
  logic tog_rise, tog_fall;
  logic byte_evt;

  // The SS chain resets low, so a frame already in progress at reset
  // produces no fall edge; a fresh frame needs SS to be seen high first.
  spi_sync_edge #(.STAGES(SYNC_STAGES)) u_ss_sync (
    .clk    (clk),
    .rst_n  (rst_n),
    .d_i    (spi_ss),
    .rise_o (ss_rise),
    .fall_o (ss_fall)
  );

  spi_sync_edge #(.STAGES(SYNC_STAGES)) u_tog_sync (
    .clk    (clk),
    .rst_n  (rst_n),
    .d_i    (rx_toggle),
    .rise_o (tog_rise),
    .fall_o (tog_fall)
  );

  assign byte_evt = tog_rise | tog_fall;

  state_e                 state_q, state_d;
  logic [DATA_LENGTH-1:0] tx_q, tx_d;
  logic [ADDR_W-1:0]      addr_q, addr_d;
  logic [DATA_LENGTH-1:0] hold_q;
  logic                   we_q, we_d;
  logic                   re_q, re_d;
  logic                   busy_q, busy_d;
  logic                   err_q, err_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      tx_q    <= FILL_BYTE;
      addr_q  <= '0;
      hold_q  <= '0;
      we_q    <= 1'b0;
      re_q    <= 1'b0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      tx_q    <= tx_d;
      addr_q  <= addr_d;
      we_q    <= we_d;
      re_q    <= re_d;
      busy_q  <= busy_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
      if (byte_evt) begin
        hold_q <= rx_byte;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    tx_d    = tx_q;
    addr_d  = addr_q;
    we_d    = 1'b0;
    re_d    = 1'b0;
    busy_d  = busy_q;
    err_d   = err_q;
    cnt_d   = cnt_q;

    // Post-increment follows every write strobe, even one issued as SS rises.
    if (we_q) begin
      addr_d = addr_q + ADDR_W'(1);
    end

    if (ss_rise) begin
      state_d = IDLE;
      busy_d  = 1'b0;
      tx_d    = FILL_BYTE;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (ss_fall) begin
            state_d = CMD;
            busy_d  = 1'b1;
            err_d   = 1'b0;
            tx_d    = FILL_BYTE;
          end
        end

        CMD: begin
          if (byte_evt) begin
            addr_d = rx_byte[ADDR_W-1:0];
            if (is_read_cmd(rx_byte)) begin
              re_d    = 1'b1;
              cnt_d   = '0;
              state_d = RD_WAIT;
            end else begin
              state_d = WR;
            end
          end
        end

        WR: begin
          if (byte_evt) begin
            we_d = 1'b1;
          end
        end

        RD_WAIT: begin
          // A byte finishing before the data is back is an overrun.
          if (byte_evt) begin
            err_d = 1'b1;
          end
          if (reg_rvalid) begin
            tx_d    = reg_rdata;
            addr_d  = addr_q + ADDR_W'(1);
            state_d = RD_STREAM;
          end else if (cnt_q == TO_LAST) begin
            tx_d    = FILL_BYTE;
            err_d   = 1'b1;
            state_d = RD_STREAM;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end

        RD_STREAM: begin
          if (byte_evt) begin
            re_d    = 1'b1;
            cnt_d   = '0;
            state_d = RD_WAIT;
          end
        end

        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  assign tx_byte    = tx_q;
  assign reg_addr   = addr_q;
  assign reg_wdata  = hold_q;
  assign reg_we     = we_q;
  assign reg_re     = re_q;
  assign busy       = busy_q;
  assign err_sticky = err_q;

endmodule

// File: tb/tb_spi_reg_ctrl.sv
// Directed bench for spi_reg_ctrl: table of write/read frames plus hand
// sequences for timeout, overrun, abort and mid-frame reset.
module tb_spi_reg_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       spi_ss;
  logic       rx_toggle;
  logic [7:0] rx_byte;
  logic [7:0] tx_byte;
  logic [6:0] reg_addr;
  logic [7:0] reg_wdata;
  logic       reg_we;
  logic       reg_re;
  logic [7:0] reg_rdata;
  logic       reg_rvalid;
  logic       busy;
  logic       err_sticky;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  spi_reg_ctrl dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .spi_ss     (spi_ss),
    .rx_toggle  (rx_toggle),
    .rx_byte    (rx_byte),
    .tx_byte    (tx_byte),
    .reg_addr   (reg_addr),
    .reg_wdata  (reg_wdata),
    .reg_we     (reg_we),
    .reg_re     (reg_re),
    .reg_rdata  (reg_rdata),
    .reg_rvalid (reg_rvalid),
    .busy       (busy),
    .err_sticky (err_sticky)
  );

  // ---------------- register-bus responder and logs ----------------
  logic [7:0]  mem     [128];
  bit          written [128];
  logic [14:0] we_log  [$];
  logic [6:0]  re_log  [$];
  logic [7:0]  tx_seen [$];
  int          rd_lat;
  int          pend;
  int          overlap;
  logic [6:0]  rv_addr;

  function automatic logic [7:0] preload(input logic [6:0] a);
    case (a)
      7'h20:   return 8'h5A;
      7'h21:   return 8'hC3;
      7'h22:   return 8'h3C;
      7'h7F:   return 8'h11;
      7'h00:   return 8'h22;
      7'h30:   return 8'h77;
      default: return 8'h00;
    endcase
  endfunction

  always @(negedge clk) begin
    reg_rvalid = 1'b0;
    if (pend > 0) begin
      pend = pend - 1;
      if (pend == 0) begin
        reg_rvalid = 1'b1;
        reg_rdata  = written[rv_addr] ? mem[rv_addr] : preload(rv_addr);
      end
    end
    if (rst_n === 1'b1) begin
      if (reg_we && reg_re) overlap = overlap + 1;
      if (reg_we) begin
        mem[reg_addr]     = reg_wdata;
        written[reg_addr] = 1'b1;
        we_log.push_back({reg_addr, reg_wdata});
      end
      if (reg_re) begin
        re_log.push_back(reg_addr);
        if (rd_lat > 0) begin
          pend    = rd_lat;
          rv_addr = reg_addr;
        end
      end
    end
  end

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic toggle_byte(input logic [7:0] b);
    tx_seen.push_back(tx_byte);
    rx_byte   = b;
    rx_toggle = ~rx_toggle;
  endtask

  task automatic send_byte(input logic [7:0] b);
    toggle_byte(b);
    wait_clk(10);
  endtask

  task automatic wait_re(input string name);
    int k;
    k = 0;
    while (reg_re !== 1'b1 && k < 30) begin
      wait_clk(1);
      k++;
    end
    check(name, {31'd0, reg_re}, 32'd1);
  endtask

  // ---------------- vector table ----------------
  typedef struct packed {
    logic [3:0][7:0] b;   // b[0] is the command byte
    logic [2:0]      n;   // bytes following the command
    logic [2:0][6:0] ea;  // expected write / read-strobe addresses
    logic [2:0][7:0] ev;  // expected write data / bytes returned to master
  } vec_t;

  localparam int NV = 6;
  vec_t vecs [NV];

  function automatic vec_t mk(input logic [7:0] c, d1, d2, d3, input int n,
                              input logic [6:0] a0, a1, a2,
                              input logic [7:0] v0, v1, v2);
    vec_t v;
    v.b  = {d3, d2, d1, c};
    v.n  = 3'(n);
    v.ea = {a2, a1, a0};
    v.ev = {v2, v1, v0};
    return v;
  endfunction

  task automatic run_vec(input vec_t v, input int idx);
    int  wb, rb, tb0, n;
    bit  is_rd;
    n     = int'(v.n);
    is_rd = v.b[0][7];
    wb    = we_log.size();
    rb    = re_log.size();
    tb0   = tx_seen.size();
    spi_ss = 1'b0;
    wait_clk(6);
    check($sformatf("v%0d_busy_on", idx), {31'd0, busy}, 32'd1);
    for (int k = 0; k <= n; k++) send_byte(v.b[k]);
    spi_ss = 1'b1;
    wait_clk(1);
    check($sformatf("v%0d_busy_hold", idx), {31'd0, busy}, 32'd1);
    wait_clk(3);
    check($sformatf("v%0d_busy_off", idx), {31'd0, busy}, 32'd0);
    wait_clk(4);
    if (is_rd) begin
      check($sformatf("v%0d_we_cnt", idx), we_log.size() - wb, 0);
      for (int k = 0; k < n; k++) begin
        if (rb + k < re_log.size())
          check($sformatf("v%0d_re_addr%0d", idx, k), {25'd0, re_log[rb + k]}, {25'd0, v.ea[k]});
        else
          check($sformatf("v%0d_re_missing%0d", idx, k), 0, 1);
        check($sformatf("v%0d_tx%0d", idx, k), {24'd0, tx_seen[tb0 + k]}, {24'd0, v.ev[k]});
      end
    end else begin
      check($sformatf("v%0d_we_cnt", idx), we_log.size() - wb, n);
      check($sformatf("v%0d_re_cnt", idx), re_log.size() - rb, 0);
      for (int k = 0; k < n; k++) begin
        if (wb + k < we_log.size()) begin
          check($sformatf("v%0d_we_addr%0d", idx, k), {25'd0, we_log[wb + k][14:8]}, {25'd0, v.ea[k]});
          check($sformatf("v%0d_we_data%0d", idx, k), {24'd0, we_log[wb + k][7:0]}, {24'd0, v.ev[k]});
        end
      end
    end
    check($sformatf("v%0d_err", idx), {31'd0, err_sticky}, 32'd0);
    check($sformatf("v%0d_tx_idle", idx), {24'd0, tx_byte}, 32'hA5);
  endtask

  // ---------------- main sequence ----------------
  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int wb, rb;
    rst_n     = 1'b0;
    spi_ss    = 1'b1;
    rx_toggle = 1'b0;
    rx_byte   = 8'h00;
    rd_lat    = 2;

    vecs[0] = mk(8'hA0, 8'h00, 8'h00, 8'h00, 3, 7'h20, 7'h21, 7'h22, 8'hA5, 8'h5A, 8'hC3);
    vecs[1] = mk(8'hFF, 8'h00, 8'h00, 8'h00, 2, 7'h7F, 7'h00, 7'h00, 8'hA5, 8'h11, 8'h00);
    vecs[2] = mk(8'h10, 8'h11, 8'h22, 8'h33, 3, 7'h10, 7'h11, 7'h12, 8'h11, 8'h22, 8'h33);
    vecs[3] = mk(8'h7F, 8'hAA, 8'h55, 8'h00, 2, 7'h7F, 7'h00, 7'h00, 8'hAA, 8'h55, 8'h00);
    vecs[4] = mk(8'h05, 8'h01, 8'h00, 8'h00, 1, 7'h05, 7'h00, 7'h00, 8'h01, 8'h00, 8'h00);
    vecs[5] = mk(8'h90, 8'h00, 8'h00, 8'h00, 2, 7'h10, 7'h11, 7'h00, 8'hA5, 8'h11, 8'h00);

    wait_clk(3);
    check("rst_tx",    {24'd0, tx_byte},   32'hA5);
    check("rst_addr",  {25'd0, reg_addr},  32'h0);
    check("rst_wdata", {24'd0, reg_wdata}, 32'h0);
    check("rst_we",    {31'd0, reg_we},    32'd0);
    check("rst_re",    {31'd0, reg_re},    32'd0);
    check("rst_busy",  {31'd0, busy},      32'd0);
    check("rst_err",   {31'd0, err_sticky}, 32'd0);
    rst_n = 1'b1;
    wait_clk(6);
    check("idle_busy", {31'd0, busy}, 32'd0);

    for (int i = 0; i < NV; i++) run_vec(vecs[i], i);

    // Read timeout: first slot returns data, the next read never answers.
    spi_ss = 1'b0;
    wait_clk(6);
    send_byte(8'hA0);
    check("to_first_data", {24'd0, tx_byte}, 32'h5A);
    rd_lat = 0;
    toggle_byte(8'h00);
    wait_re("to_re");
    wait_clk(12);
    check("to_err_early", {31'd0, err_sticky}, 32'd0);
    check("to_tx_hold",   {24'd0, tx_byte},    32'h5A);
    wait_clk(4);
    check("to_err",       {31'd0, err_sticky}, 32'd1);
    check("to_tx_fill",   {24'd0, tx_byte},    32'hA5);
    spi_ss = 1'b1;
    wait_clk(8);
    check("to_err_sticky", {31'd0, err_sticky}, 32'd1);
    spi_ss = 1'b0;
    wait_clk(6);
    check("to_err_clear", {31'd0, err_sticky}, 32'd0);

    // Overrun: a second byte completes while the read is still outstanding.
    toggle_byte(8'hC0);
    wait_re("ovr_re");
    toggle_byte(8'h00);
    wait_clk(6);
    check("ovr_err", {31'd0, err_sticky}, 32'd1);
    spi_ss = 1'b1;
    wait_clk(20);

    // Abort: SS rises while waiting; the late 0x77 must not reach tx_byte.
    rd_lat = 12;
    spi_ss = 1'b0;
    wait_clk(6);
    rb = re_log.size();
    toggle_byte(8'hB0);
    wait_re("ab_re");
    check("ab_re_addr", {25'd0, reg_addr}, 32'h30);
    spi_ss = 1'b1;
    wait_clk(25);
    check("ab_tx",     {24'd0, tx_byte}, 32'hA5);
    check("ab_busy",   {31'd0, busy},    32'd0);
    check("ab_re_cnt", re_log.size() - rb, 1);
    rd_lat = 2;

    // Asynchronous reset in the middle of a write burst.
    wb = we_log.size();
    spi_ss = 1'b0;
    wait_clk(6);
    send_byte(8'h40);
    send_byte(8'h01);
    toggle_byte(8'h02);
    wait_clk(3);
    check("mr_we_pre",   {31'd0, reg_we},   32'd1);
    check("mr_addr_pre", {25'd0, reg_addr}, 32'h41);
    check("mr_first_we", we_log.size() - wb, 1);
    rst_n = 1'b0;
    #1;
    check("mr_we",    {31'd0, reg_we},     32'd0);
    check("mr_addr",  {25'd0, reg_addr},   32'h0);
    check("mr_wdata", {24'd0, reg_wdata},  32'h0);
    check("mr_tx",    {24'd0, tx_byte},    32'hA5);
    check("mr_busy",  {31'd0, busy},       32'd0);
    wait_clk(2);
    rst_n = 1'b1;
    wb = we_log.size();
    send_byte(8'h41);
    send_byte(8'h03);
    wait_clk(4);
    check("mr_no_we",   we_log.size() - wb, 0);
    check("mr_no_busy", {31'd0, busy}, 32'd0);
    spi_ss = 1'b1;
    wait_clk(8);
    spi_ss = 1'b0;
    wait_clk(6);
    send_byte(8'h45);
    send_byte(8'h99);
    spi_ss = 1'b1;
    wait_clk(8);
    check("mr_fresh_cnt", we_log.size() - wb, 1);
    if (we_log.size() > wb) begin
      check("mr_fresh_we", {17'd0, we_log[wb]}, {17'd0, 7'h45, 8'h99});
    end

    check("we_re_exclusive", overlap, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/spi_reg_ctrl.md
Name: spi_reg_ctrl

Overview:
- System-clock-domain sequencer that turns the byte stream from the SPI slave core into register-bus transactions.
- First byte of each SS-low frame is a command (bit7 = 1 read / 0 write, bits6:0 = start address); following bytes are write data or read slots, with the address auto-incrementing.
- Synchronises the slave's SCLK-domain signals, drives the slave's transmit byte, and owns a simple request/valid register-bus master port.

Parameters:
- ADDR_W, 7, register address width (fixed to command bits6:0; values other than 7 are not supported)
- SYNC_STAGES, 2, flip-flop stages on each asynchronous input (minimum 2)
- RD_TIMEOUT, 15, clk cycles to wait for reg_rvalid before the read is declared failed
- FILL_BYTE, 8'hA5, byte placed on tx_byte when no read data is available

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- spi_ss  in  1  slave select from pad, active low, asynchronous to clk
- rx_toggle  in  1  slave byte-complete toggle, SCLK domain; each edge means one byte is done
- rx_byte  in  8  received byte, stable for at least 4 clk after its rx_toggle edge
- tx_byte  out  8  byte the slave loads for the next transfer (drives data_to_master)
- reg_addr  out  ADDR_W  register address
- reg_wdata  out  8  write data
- reg_we  out  1  one-cycle write strobe
- reg_re  out  1  one-cycle read strobe
- reg_rdata  in  8  read data
- reg_rvalid  in  1  read data valid; returns at least 1 cycle after reg_re
- busy  out  1  high while a frame is active (synchronised SS low)
- err_sticky  out  1  read timeout or overrun has occurred; cleared when a new frame starts

Behaviour:
- Reset values: tx_byte=FILL_BYTE, reg_addr=0, reg_wdata=0, reg_we=0, reg_re=0, busy=0, err_sticky=0, state=IDLE.
- Input synchronisation:
  - spi_ss and rx_toggle each pass through SYNC_STAGES flip-flops.
  - byte_evt is a one-cycle pulse when the synchronised toggle differs from its previous value.
  - rx_byte is captured into a holding register in the same cycle byte_evt is asserted.
- States:
  - IDLE: wait for synchronised SS to fall, then go to CMD. Set busy=1, clear err_sticky, set tx_byte=FILL_BYTE.
  - CMD: on byte_evt, reg_addr<=byte[6:0]. If byte[7]=0 go to WR. If byte[7]=1, pulse reg_re on the next cycle and go to RD_WAIT.
  - WR: on each byte_evt, reg_wdata<=byte and pulse reg_we for one cycle. On the following cycle, reg_addr<=reg_addr+1.
  - RD_WAIT:
    - On reg_rvalid: tx_byte<=reg_rdata, reg_addr<=reg_addr+1, go to RD_STREAM.
    - If RD_TIMEOUT cycles pass without reg_rvalid: tx_byte<=FILL_BYTE, set err_sticky, go to RD_STREAM.
  - RD_STREAM: on byte_evt (the master clocked out the current tx_byte), pulse reg_re on the next cycle and go back to RD_WAIT. The incoming byte is ignored.
- Read latency contract: the slave loads tx_byte at the end of a byte, so the data for the command address appears in the 2nd byte after the command. The 1st byte after the command returns FILL_BYTE.
- Address wrap: reg_addr increments modulo 2^ADDR_W (127 -> 0) with no error.
- Overrun: a byte_evt while in RD_WAIT sets err_sticky. The read in progress completes; the extra byte is not queued.
- SS rise (synchronised), in any state:
  - Go to IDLE next cycle, set busy=0, set tx_byte=FILL_BYTE.
  - An outstanding read is abandoned and a late reg_rvalid is ignored.
  - A reg_we pulse issued in the same cycle still completes.
- Simultaneous byte_evt and SS rise in the same cycle: SS rise wins; no bus strobe is issued.
- Async reset mid-frame: everything returns to reset values immediately. Until synchronised SS has been seen high, IDLE does not start a frame, so no partial frame is processed after reset.
- reg_we and reg_re are never high in the same cycle. Each is high for at most 1 cycle per byte.

Decomposition:
- Shared package spi_pkg:
  - state encoding: IDLE, CMD, WR, RD_WAIT, RD_STREAM
  - CMD_RD_BIT=7
  - FILL_BYTE default
  - DATA_LENGTH=8, shared with the slave core
- One sub-module, spi_sync_edge: an N-stage synchroniser with toggle/edge detect. Instantiated twice, for spi_ss (fall/rise pulses) and rx_toggle (byte_evt).

Test Plan:
- Write burst: SS low, bytes 0x10,0x11,0x22,0x33 -> reg_we pulses with (addr,data) = (0x10,0x11), (0x11,0x22), (0x12,0x33); busy drops 2-3 clk after SS rises.
- Read burst: memory[0x20..0x21] = 0x5A,0xC3, bytes 0xA0,x,x,x -> tx_byte sequence FILL(0xA5), 0x5A, 0xC3; reg_re issued for 0x20, 0x21, 0x22.
- Wrap: write command 0x7F followed by 2 data bytes -> writes land at addresses 0x7F then 0x00; err_sticky stays 0.
- Read timeout: reg_rvalid never asserted -> after 15 clk, tx_byte=0xA5 and err_sticky=1; the next frame clears err_sticky.
- Abort: SS rises while in RD_WAIT, then reg_rvalid arrives with 0x77 -> tx_byte stays 0xA5, state is IDLE, no further reg_re.
- Reset: rst_n pulsed low mid-write-burst -> all outputs at reset values within the same cycle; no reg_we until a fresh SS fall followed by a command byte.
